// File: rtl/tea_host_ctrl_if.sv
// Block-in / result-out handshake bundle between the bus front end and tea_host_ctrl.
interface tea_host_ctrl_if #(
    parameter int WORD_SIZE = 32
);
    logic                 iBlkValid;
    logic                 oBlkReady;
    logic [WORD_SIZE-1:0] iBlkV0;
    logic [WORD_SIZE-1:0] iBlkV1;
    logic                 iBlkMode;
    logic                 oResValid;
    logic                 iResReady;
    logic [WORD_SIZE-1:0] oResC0;
    logic [WORD_SIZE-1:0] oResC1;
    logic                 oResMode;
    logic                 oResErr;

    modport master (
        output iBlkValid, iBlkV0, iBlkV1, iBlkMode, iResReady,
        input  oBlkReady, oResValid, oResC0, oResC1, oResMode, oResErr
    );

    modport slave (
        input  iBlkValid, iBlkV0, iBlkV1, iBlkMode, iResReady,
        output oBlkReady, oResValid, oResC0, oResC1, oResMode, oResErr
    );
endinterface

// File: rtl/tea_host_ctrl.sv
// Host-side initiator for the TEA engine: key file, block/result handshakes, start sequencing.
// Optional RUN watchdog enabled by defining TEA_HOST_TIMEOUT_EN.
module tea_host_ctrl #(
    parameter int WORD_SIZE      = 32,
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    tea_host_ctrl_if.slave         host,
    input  logic                   iKeyWe,
    input  logic [1:0]             iKeyAddr,
    input  logic [WORD_SIZE-1:0]   iKeyData,
    output logic                   oKeyWrErr,
    output logic [COUNT_WIDTH-1:0] oBlkCount,
    output logic [WORD_SIZE-1:0]   oV0,
    output logic [WORD_SIZE-1:0]   oV1,
    output logic                   oStartCipher,
    output logic                   oStartDecipher,
    input  logic [1:0]             iKeyAddress,
    output logic [WORD_SIZE-1:0]   oKeySubI,
    input  logic [WORD_SIZE-1:0]   iC0,
    input  logic [WORD_SIZE-1:0]   iC1,
    input  logic                   iDone
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} stateT;

    stateT                  state, stateNext;
    logic [WORD_SIZE-1:0]   keyReg [4];
    logic                   modeReg, modeNext;
    logic                   firstRun, firstRunNext;
    logic                   blkReadyNext, resValidNext, resModeNext, keyWrErrNext;
    logic                   startCipherNext, startDecipherNext;
    logic [WORD_SIZE-1:0]   v0Next, v1Next, resC0Next, resC1Next;
    logic [COUNT_WIDTH-1:0] blkCountNext;

`ifdef TEA_HOST_TIMEOUT_EN
    localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_WIDTH-1:0] timer, timerNext;
    logic                   resErrNext;
`endif

    assign oKeySubI = keyReg[iKeyAddress];

    // Keys are only writable while no block is in flight so the engine never sees a torn key.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) keyReg[i] <= '0;
        end else if (iKeyWe && state == IDLE) begin
            keyReg[iKeyAddr] <= iKeyData;
        end
    end

    always_comb begin
        stateNext         = state;
        modeNext          = modeReg;
        firstRunNext      = firstRun;
        blkReadyNext      = 1'b0;
        resValidNext      = host.oResValid;
        resModeNext       = host.oResMode;
        resC0Next         = host.oResC0;
        resC1Next         = host.oResC1;
        v0Next            = oV0;
        v1Next            = oV1;
        startCipherNext   = oStartCipher;
        startDecipherNext = oStartDecipher;
        blkCountNext      = oBlkCount;
        keyWrErrNext      = iKeyWe && (state != IDLE);
`ifdef TEA_HOST_TIMEOUT_EN
        timerNext         = timer;
        resErrNext        = host.oResErr;
`endif
        unique case (state)
            IDLE: begin
                blkReadyNext      = 1'b1;
                resValidNext      = 1'b0;
                startCipherNext   = 1'b0;
                startDecipherNext = 1'b0;
                if (host.iBlkValid && host.oBlkReady) begin
                    v0Next            = host.iBlkV0;
                    v1Next            = host.iBlkV1;
                    modeNext          = host.iBlkMode;
                    startCipherNext   = !host.iBlkMode;
                    startDecipherNext = host.iBlkMode;
                    blkReadyNext      = 1'b0;
                    firstRunNext      = 1'b1;
                    stateNext         = RUN;
`ifdef TEA_HOST_TIMEOUT_EN
                    timerNext         = '0;
`endif
                end
            end
            RUN: begin
                // The first RUN cycle may still show done from the previous block, so it is masked.
                firstRunNext = 1'b0;
`ifdef TEA_HOST_TIMEOUT_EN
                timerNext    = timer + 1'b1;
`endif
                if (!firstRun && iDone) begin
                    resC0Next         = iC0;
                    resC1Next         = iC1;
                    resModeNext       = modeReg;
                    resValidNext      = 1'b1;
                    startCipherNext   = 1'b0;
                    startDecipherNext = 1'b0;
                    stateNext         = DRAIN;
`ifdef TEA_HOST_TIMEOUT_EN
                    resErrNext        = 1'b0;
                end else if (timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    resC0Next         = '0;
                    resC1Next         = '0;
                    resModeNext       = modeReg;
                    resErrNext        = 1'b1;
                    resValidNext      = 1'b1;
                    startCipherNext   = 1'b0;
                    startDecipherNext = 1'b0;
                    stateNext         = DRAIN;
`endif
                end
            end
            DRAIN: begin
                startCipherNext   = 1'b0;
                startDecipherNext = 1'b0;
                if (host.iResReady) begin
                    resValidNext = 1'b0;
                    blkCountNext = oBlkCount + 1'b1;
                    blkReadyNext = 1'b1;
                    stateNext    = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // All outputs are registered; async reset drops the start lines immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            modeReg        <= 1'b0;
            firstRun       <= 1'b0;
            host.oBlkReady <= 1'b0;
            host.oResValid <= 1'b0;
            host.oResMode  <= 1'b0;
            host.oResC0    <= '0;
            host.oResC1    <= '0;
            oV0            <= '0;
            oV1            <= '0;
            oStartCipher   <= 1'b0;
            oStartDecipher <= 1'b0;
            oBlkCount      <= '0;
            oKeyWrErr      <= 1'b0;
        end else begin
            state          <= stateNext;
            modeReg        <= modeNext;
            firstRun       <= firstRunNext;
            host.oBlkReady <= blkReadyNext;
            host.oResValid <= resValidNext;
            host.oResMode  <= resModeNext;
            host.oResC0    <= resC0Next;
            host.oResC1    <= resC1Next;
            oV0            <= v0Next;
            oV1            <= v1Next;
            oStartCipher   <= startCipherNext;
            oStartDecipher <= startDecipherNext;
            oBlkCount      <= blkCountNext;
            oKeyWrErr      <= keyWrErrNext;
        end
    end

`ifdef TEA_HOST_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer        <= '0;
            host.oResErr <= 1'b0;
        end else begin
            timer        <= timerNext;
            host.oResErr <= resErrNext;
        end
    end
`else
    assign host.oResErr = 1'b0;
`endif

endmodule

// File: tb/tb_tea_host_ctrl.sv
// Bench for tea_host_ctrl: behavioural TEA engine stub, table vectors, random blocks and corner sequences.
module tb_tea_host_ctrl;
    localparam int WS = 32;
    localparam int CW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          iKeyWe = 1'b0;
    logic [1:0]    iKeyAddr = '0;
    logic [WS-1:0] iKeyData = '0;
    logic          oKeyWrErr;
    logic [CW-1:0] oBlkCount;
    logic [WS-1:0] oV0, oV1, oKeySubI, iC0, iC1;
    logic          oStartCipher, oStartDecipher, iDone;
    logic [1:0]    iKeyAddress;

    always #5 clk = ~clk;

    tea_host_ctrl_if #(.WORD_SIZE(WS)) host ();

    tea_host_ctrl #(.WORD_SIZE(WS), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .host(host),
        .iKeyWe(iKeyWe), .iKeyAddr(iKeyAddr), .iKeyData(iKeyData),
        .oKeyWrErr(oKeyWrErr), .oBlkCount(oBlkCount),
        .oV0(oV0), .oV1(oV1), .oStartCipher(oStartCipher), .oStartDecipher(oStartDecipher),
        .iKeyAddress(iKeyAddress), .oKeySubI(oKeySubI),
        .iC0(iC0), .iC1(iC1), .iDone(iDone)
    );

    function automatic logic [63:0] teaEnc(input logic [31:0] a, b, k0, k1, k2, k3);
        logic [31:0] v0, v1, sum;
        v0 = a; v1 = b; sum = 32'h0;
        for (int r = 0; r < 32; r++) begin
            sum = sum + 32'h9E3779B9;
            v0  = v0 + ((((v1 << 4) + k0) ^ (v1 + sum)) ^ ((v1 >> 5) + k1));
            v1  = v1 + ((((v0 << 4) + k2) ^ (v0 + sum)) ^ ((v0 >> 5) + k3));
        end
        return {v0, v1};
    endfunction

    function automatic logic [63:0] teaDec(input logic [31:0] a, b, k0, k1, k2, k3);
        logic [31:0] v0, v1, sum;
        v0 = a; v1 = b; sum = 32'hC6EF3720;
        for (int r = 0; r < 32; r++) begin
            v1  = v1 - ((((v0 << 4) + k2) ^ (v0 + sum)) ^ ((v0 >> 5) + k3));
            v0  = v0 - ((((v1 << 4) + k0) ^ (v1 + sum)) ^ ((v1 >> 5) + k1));
            sum = sum - 32'h9E3779B9;
        end
        return {v0, v1};
    endfunction

    // Engine stub: fetches the key over the key port, computes TEA, and leaves done high until the next start.
    logic [1:0]    engPhase, probeAddr;
    logic [3:0]    engCnt, engLat;
    logic [WS-1:0] engKey [4];
    logic [WS-1:0] engV0, engV1;
    logic          engMode, startPrev;
    logic          engHang = 1'b0;
    logic          startAny;

    assign startAny    = oStartCipher | oStartDecipher;
    assign iKeyAddress = (engPhase == 2'd1) ? engCnt[1:0] : probeAddr;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            engPhase <= 2'd0; engCnt <= '0; engLat <= 4'd4; iDone <= 1'b0;
            iC0 <= '0; iC1 <= '0; startPrev <= 1'b0;
        end else begin
            startPrev <= startAny;
            if (startAny && !startPrev) begin
                engPhase <= 2'd1; engCnt <= '0; iDone <= 1'b0;
                engV0 <= oV0; engV1 <= oV1; engMode <= oStartDecipher;
                engLat <= 4'($urandom_range(4, 9));
            end else if (engPhase == 2'd1) begin
                if (!startAny) engPhase <= 2'd0;
                else begin
                    if (engCnt < 4'd4) engKey[engCnt[1:0]] <= oKeySubI;
                    if (!engHang && engCnt == engLat) begin
                        {iC0, iC1} <= engMode ? teaDec(engV0, engV1, engKey[0], engKey[1], engKey[2], engKey[3])
                                              : teaEnc(engV0, engV1, engKey[0], engKey[1], engKey[2], engKey[3]);
                        iDone    <= 1'b1;
                        engPhase <= 2'd2;
                    end else engCnt <= engCnt + 4'd1;
                end
            end
        end
    end

    int            total = 0;
    int            bad   = 0;
    logic [WS-1:0] mKey [4];
    logic [CW-1:0] mCount;

    function automatic logic [63:0] modelResult(input logic [31:0] v0, v1, input logic m);
        return m ? teaDec(v0, v1, mKey[0], mKey[1], mKey[2], mKey[3])
                 : teaEnc(v0, v1, mKey[0], mKey[1], mKey[2], mKey[3]);
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeKey(input logic [1:0] a, input logic [31:0] d);
        iKeyWe = 1'b1; iKeyAddr = a; iKeyData = d;
        tick();
        iKeyWe = 1'b0;
        mKey[a] = d;
        checkOutput("keyWrErrIdle", 128'(oKeyWrErr), 128'(0));
    endtask

    task automatic checkKey(input logic [1:0] a, input string name);
        probeAddr = a;
        #1;
        checkOutput(name, 128'(oKeySubI), 128'(mKey[a]));
    endtask

    task automatic acceptBlock(input logic [31:0] v0, v1, input logic m, input string name);
        int n = 0;
        while (!host.oBlkReady && n < 50) begin tick(); n++; end
        checkOutput({name, " ready"}, 128'(host.oBlkReady), 128'(1));
        host.iBlkValid = 1'b1; host.iBlkV0 = v0; host.iBlkV1 = v1; host.iBlkMode = m;
        tick();
        host.iBlkValid = 1'b0;
        checkOutput({name, " start"}, 128'({oStartCipher, oStartDecipher, host.oBlkReady, oV0, oV1}),
                    128'({!m, m, 1'b0, v0, v1}));
    endtask

    task automatic waitAndCollect(input logic m, input logic [63:0] exp, input logic err,
                                  input int hold, input logic press, input string name);
        int n = 0;
        while (!host.oResValid && n < 200) begin tick(); n++; end
        checkOutput({name, " result"},
                    128'({host.oResValid, host.oResC0, host.oResC1, host.oResMode, host.oResErr, startAny}),
                    128'({1'b1, exp, m, err, 1'b0}));
        if (press) host.iBlkValid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            tick();
            checkOutput({name, " hold"},
                        128'({host.oResValid, host.oResC0, host.oResC1, host.oResMode, host.oBlkReady, startAny}),
                        128'({1'b1, exp, m, 1'b0, 1'b0}));
        end
        host.iResReady = 1'b1;
        tick();
        host.iResReady = 1'b0;
        mCount = mCount + 1'b1;
        checkOutput({name, " handshake"},
                    128'({host.oResValid, oBlkCount, host.oBlkReady, startAny}),
                    128'({1'b0, mCount, 1'b1, 1'b0}));
    endtask

    task automatic applyStimulus(input logic [31:0] v0, v1, input logic m, input logic [63:0] exp,
                                 input int hold, input logic press, input string name);
        acceptBlock(v0, v1, m, name);
        waitAndCollect(m, exp, 1'b0, hold, press, name);
    endtask

    typedef struct {
        logic [31:0] v0;
        logic [31:0] v1;
        logic        mode;
        logic [63:0] exp;
        int          hold;
    } vecT;

    vecT vecs [4];

    initial begin
        host.iBlkValid = 1'b0; host.iBlkV0 = '0; host.iBlkV1 = '0; host.iBlkMode = 1'b0;
        host.iResReady = 1'b0; probeAddr = 2'd0; mCount = '0;
        for (int i = 0; i < 4; i++) mKey[i] = '0;

        #2 rst = 1'b0;
        #1;
        checkOutput("resetA", 128'({host.oBlkReady, host.oResValid, host.oResC0, host.oResC1, host.oResMode, host.oResErr}), 128'(0));
        checkOutput("resetB", 128'({oKeyWrErr, oBlkCount, oV0, oV1, oStartCipher, oStartDecipher}), 128'(0));
        tick(); tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) writeKey(2'(i), 32'h1111_1111 * (i + 1));
        for (int i = 0; i < 4; i++) checkKey(2'(i), "keyReadback");
        for (int i = 0; i < 4; i++) writeKey(2'(i), 32'h0);
        checkKey(2'd3, "keyZero");

        vecs[0] = '{32'h0, 32'h0, 1'b0, 64'h41EA3A0A_94BAA940, 0};
        vecs[1] = '{32'h41EA3A0A, 32'h94BAA940, 1'b1, 64'h0, 2};
        vecs[2] = '{32'h01234567, 32'h89ABCDEF, 1'b0, modelResult(32'h01234567, 32'h89ABCDEF, 1'b0), 1};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, modelResult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1), 0};
        for (int i = 0; i < 4; i++)
            applyStimulus(vecs[i].v0, vecs[i].v1, vecs[i].mode, vecs[i].exp, vecs[i].hold, 1'b0, "vector");

        // Key write during RUN must be rejected and flagged for exactly one cycle.
        writeKey(2'd0, 32'hA56B_1234); writeKey(2'd1, 32'h0F0F_7777);
        writeKey(2'd2, 32'h1357_9BDF); writeKey(2'd3, 32'hCAFE_0042);
        acceptBlock(32'h0BAD_F00D, 32'h1234_5678, 1'b0, "runWrite");
        iKeyWe = 1'b1; iKeyAddr = 2'd2; iKeyData = 32'hDEAD_BEEF;
        tick();
        iKeyWe = 1'b0;
        checkOutput("keyWrErrPulse", 128'(oKeyWrErr), 128'(1));
        tick();
        checkOutput("keyWrErrClear", 128'(oKeyWrErr), 128'(0));
        waitAndCollect(1'b0, modelResult(32'h0BAD_F00D, 32'h1234_5678, 1'b0), 1'b0, 0, 1'b0, "runWrite");
        checkKey(2'd2, "keyAfterRunWrite");

        for (int i = 0; i < 16; i++) begin
            logic [31:0] rv0, rv1;
            logic        rm;
            if (i % 4 == 0) writeKey(2'($urandom_range(0, 3)), $urandom);
            rv0 = $urandom; rv1 = $urandom; rm = 1'($urandom_range(0, 1));
            applyStimulus(rv0, rv1, rm, modelResult(rv0, rv1, rm), $urandom_range(0, 3), 1'b0, "random");
        end

        // Long DRAIN stall with a waiting block: it is accepted only in the IDLE cycle after the handshake.
        applyStimulus(32'h0000_0001, 32'h0000_0002, 1'b0, modelResult(32'h1, 32'h2, 1'b0), 10, 1'b1, "drainHold");
        applyStimulus(32'h0000_0003, 32'h0000_0004, 1'b1, modelResult(32'h3, 32'h4, 1'b1), 0, 1'b0, "afterDrain");

        acceptBlock(32'h5555_AAAA, 32'hAAAA_5555, 1'b1, "resetMidRun");
        tick();
        rst = 1'b0;
        #1;
        checkOutput("resetMidRun outs", 128'({startAny, host.oResValid, oBlkCount}), 128'(0));
        for (int i = 0; i < 4; i++) mKey[i] = '0;
        mCount = '0;
        for (int i = 0; i < 4; i++) checkKey(2'(i), "keyAfterReset");
        tick();
        rst = 1'b1;
        tick();
        applyStimulus(32'h0, 32'h0, 1'b0, 64'h41EA3A0A_94BAA940, 0, 1'b0, "postReset");

        begin
            int n = 0;
            engHang = 1'b1;
            acceptBlock(32'h7777_0000, 32'h0000_7777, 1'b1, "hang");
            while (startAny && n < 40) begin tick(); n++; end
`ifdef TEA_HOST_TIMEOUT_EN
            checkOutput("timeoutRunCycles", 128'(n), 128'(TO));
            engHang = 1'b0;
            waitAndCollect(1'b1, 64'h0, 1'b1, 1, 1'b0, "timeout");
`else
            checkOutput("noTimeoutStuck", 128'({n[7:0], startAny, host.oResValid}), 128'({8'd40, 1'b1, 1'b0}));
            engHang = 1'b0;
            rst = 1'b0;
            tick();
            rst = 1'b1;
            tick();
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
